// File: rtl/sa_ctrl_pkg.sv
// Shared types and defaults for the systolic-array layer sequencer.
// The network is walked layer by layer, and tile by tile within each layer.
package sa_ctrl_pkg;

  localparam int NUM_LAYERS_DEF = 5;
  localparam int FOLD_W_DEF     = 8;
  localparam int CFG_WAIT_DEF   = 2;

  // Tile handshake: layer index width and tile coordinate width
  localparam int LAYER_W        = 4;
  localparam int TILE_COORD_W   = FOLD_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_LOAD,
    ST_TILE_ISSUE,
    ST_TILE_WAIT,
    ST_POOL_ISSUE,
    ST_POOL_WAIT,
    ST_FINISH
  } seq_state_t;

  function automatic logic is_busy_state(input seq_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/fold_counter2d.sv
// Two-level fold counter: row is the inner loop, col the outer loop.
// Limits are inclusive and compared for equality, so the counter never overflows.
module fold_counter2d #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] row_max,
  input  logic [W-1:0] col_max,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  logic row_at_max;
  logic col_at_max;

  assign row_at_max = (row == row_max);
  assign col_at_max = (col == col_max);
  assign last       = row_at_max && col_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (row_at_max) begin
        row <= '0;
        col <= col_at_max ? '0 : col + W'(1);
      end else begin
        row <= row + W'(1);
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: switches the config block, waits for it to settle, runs all
// tiles of the layer through the array, optionally pools, then moves to the next layer.
module layer_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int FOLD_W     = FOLD_W_DEF,
  parameter int CFG_WAIT   = CFG_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               net_start,
  input  logic               abort,
  output logic               layer_switch,
  input  logic [FOLD_W-1:0]  fold_rows,
  input  logic [FOLD_W-1:0]  fold_cols,
  input  logic               pooling_en,
  input  logic [LAYER_W-1:0] layer_index,
  output logic               tile_start,
  output logic [FOLD_W-1:0]  tile_row,
  output logic [FOLD_W-1:0]  tile_col,
  input  logic               tile_done,
  output logic               pool_start,
  input  logic               pool_done,
  output logic [LAYER_W-1:0] cur_layer,
  output logic               busy,
  output logic               net_done,
  output logic               cfg_err
);

  localparam int                 WAIT_W     = (CFG_WAIT > 1) ? $clog2(CFG_WAIT) : 1;
  localparam logic [WAIT_W-1:0]  LAST_WAIT  = WAIT_W'(CFG_WAIT - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS);

  seq_state_t           state_reg;
  seq_state_t           state_next;
  logic [WAIT_W-1:0]    wait_reg;
  logic [WAIT_W-1:0]    wait_next;
  logic [LAYER_W-1:0]   layer_next;
  logic [FOLD_W-1:0]    rows_lim_reg;
  logic [FOLD_W-1:0]    cols_lim_reg;
  logic                 pool_lim_reg;
  logic                 latch_cfg;
  logic                 err_set;
  logic                 cnt_clear;
  logic                 cnt_step;
  logic                 tile_last;

  fold_counter2d #(
    .W(FOLD_W)
  ) u_fold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .step    (cnt_step),
    .row_max (rows_lim_reg),
    .col_max (cols_lim_reg),
    .row     (tile_row),
    .col     (tile_col),
    .last    (tile_last)
  );

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    layer_next = cur_layer;
    latch_cfg  = 1'b0;
    err_set    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (net_start) begin
          state_next = ST_SWITCH;
          layer_next = LAYER_W'(1);
        end
      end
      ST_SWITCH: begin
        wait_next  = '0;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (wait_reg == LAST_WAIT) begin
          latch_cfg  = 1'b1;
          cnt_clear  = 1'b1;
          err_set    = (layer_index != cur_layer);
          state_next = ST_TILE_ISSUE;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      ST_TILE_ISSUE: begin
        state_next = ST_TILE_WAIT;
      end
      ST_TILE_WAIT: begin
        if (tile_done) begin
          cnt_step = 1'b1;
          if (!tile_last) begin
            state_next = ST_TILE_ISSUE;
          end else if (pool_lim_reg) begin
            state_next = ST_POOL_ISSUE;
          end else if (cur_layer < LAST_LAYER) begin
            layer_next = cur_layer + LAYER_W'(1);
            state_next = ST_SWITCH;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_POOL_ISSUE: begin
        state_next = ST_POOL_WAIT;
      end
      ST_POOL_WAIT: begin
        if (pool_done) begin
          if (cur_layer < LAST_LAYER) begin
            layer_next = cur_layer + LAYER_W'(1);
            state_next = ST_SWITCH;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        layer_next = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        layer_next = '0;
      end
    endcase

    // Abort overrides everything except the sticky error flag
    if (abort) begin
      state_next = ST_IDLE;
      wait_next  = '0;
      layer_next = '0;
      latch_cfg  = 1'b0;
      err_set    = 1'b0;
      cnt_clear  = 1'b1;
      cnt_step   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_reg     <= '0;
      cur_layer    <= '0;
      rows_lim_reg <= '0;
      cols_lim_reg <= '0;
      pool_lim_reg <= 1'b0;
      cfg_err      <= 1'b0;
      layer_switch <= 1'b0;
      tile_start   <= 1'b0;
      pool_start   <= 1'b0;
      net_done     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      cur_layer <= layer_next;
      if (latch_cfg) begin
        rows_lim_reg <= fold_rows;
        cols_lim_reg <= fold_cols;
        pool_lim_reg <= pooling_en;
      end
      if (err_set) begin
        cfg_err <= 1'b1;
      end
      // Pulses are decoded from the next state so they line up with the state itself
      layer_switch <= (state_next == ST_SWITCH) || (state_next == ST_FINISH);
      tile_start   <= (state_next == ST_TILE_ISSUE);
      pool_start   <= (state_next == ST_POOL_ISSUE);
      net_done     <= (state_next == ST_FINISH);
      busy         <= is_busy_state(state_next);
    end
  end

endmodule
